regfile_mp: RTL
===============

# regfile_mp

Parametrised multi-read-port register file for the execution-cycle datapath with one synchronous write port and NUM_RD registered read ports. After reset, an internal sequencer walks the array and loads a deterministic init pattern, then asserts `ready`. Register 0 is hardwired to zero. It replaces the fixed 2-read, read-only register store used by the decode/operand-fetch stage.

## Interface
- `DATA_W`, 32: register width; must be a multiple of 4.
- `ADDR_W`, 5: address width; DEPTH = 2**ADDR_W, with registers 1..DEPTH-1 implemented.
- `NUM_RD`, 2: number of read ports, 1..4.

- `clk` in 1: clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `wr_en` in 1: write strobe; honoured only while `ready`=1.
- `wr_addr` in ADDR_W: write address.
- `wr_data` in DATA_W: write data.
- `rd_addr` in NUM_RD*ADDR_W: packed read addresses; port p uses bits [p*ADDR_W +: ADDR_W].
- `rd_data` out NUM_RD*DATA_W: packed registered read data; port p uses bits [p*DATA_W +: DATA_W].
- `ready` out 1: init complete; reads and writes are valid.

## Operation
- Two-state FSM: INIT and READY.
- `reset` asserted: FSM goes to INIT, init index goes to 1, `ready`=0, all `rd_data`=0. Array contents are otherwise don't-care until INIT rewrites them.
- INIT, each cycle:
  - Write register[idx] = idx[3:0] replicated DATA_W/4 times. For example, reg 5 = 0x55555555 and reg 16 = 0x00000000.
  - Increment idx.
  - When idx = DEPTH-1 is written, go to READY on the next edge.
- INIT also holds: `wr_en` ignored, `rd_data` held at 0, `ready`=0.
- READY:
  - Each edge, every port p loads rd_data[p] = (rd_addr[p]==0) ? 0 : reg[rd_addr[p]].
  - If `wr_en`=1 and wr_addr≠0, reg[wr_addr] = wr_data.
  - Writes to address 0 are silently dropped.
- Multiple read ports may address the same register; all return the same value.
- Reset during INIT or READY: immediate return to INIT with `ready` deasserted. The init walk restarts from 1.
- No error outputs. Out-of-range addresses are impossible by construction.

## Timing
- Read latency: 1 cycle. An address presented before edge N appears on `rd_data` after edge N.
- Write latency: the value is visible to a read issued on the cycle after the write edge (i.e. it appears on `rd_data` 2 edges after `wr_en`). The same-cycle case is governed by Configuration.
- INIT duration: exactly DEPTH-1 cycles after `reset` deasserts (31 for ADDR_W=5). `ready` rises on the edge after the last init write.
- First valid read: the edge on which `ready` is first sampled 1 loads `rd_data`, so data is valid one cycle after `ready` rises.
- Reset values: `rd_data`=0, `ready`=0.

## Configuration
- `REGFILE_BYPASS_EN` defined: on a READY edge where `wr_en`=1, wr_addr≠0 and rd_addr[p]==wr_addr, port p loads `wr_data` (write-first).
- `REGFILE_BYPASS_EN` undefined: port p loads the pre-write contents (read-first).
- Register 0 always reads 0 in both modes.

## Structure
- Package `regfile_pkg` holds:
  - the FSM state enum (`RF_INIT`, `RF_READY`);
  - function `rf_init_pattern(idx)`, which returns the replicated-nibble value;
  - localparam `RF_MAX_RD` = 4.
- Sub-module `regfile_init_seq` holds the INIT/READY FSM and idx counter. It outputs `init_we`, `init_addr`, `init_data` and `ready`.
- The top level muxes between the init writes and the user write port and owns the array and the read registers.

## Test plan
- Reset, then wait: `ready` rises exactly 31 cycles after reset release. Reading reg 5 gives 0x55555555, reg 16 gives 0x00000000, reg 31 gives 0xFFFFFFFF.
- Read address 0 on all ports in READY: `rd_data` = 0 every cycle.
- Write reg 7 = 0xDEADBEEF, then read reg 7 on port 1 the next cycle: 0xDEADBEEF appears one cycle later.
- Write reg 0 = 0x12345678, then read reg 0: returns 0.
- Same-cycle write reg 3 = 0xCAFEF00D while reading reg 3 (reg 3 initially 0x33333333):
  - `REGFILE_BYPASS_EN` defined: returns 0xCAFEF00D.
  - Undefined: returns 0x33333333.
- Assert reset 10 cycles into INIT, release: `ready`=0 and `rd_data`=0 immediately. `ready` rises 31 cycles after the second release. A `wr_en` pulse during INIT has no effect.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared FSM state, init pattern and limits for the regfile_mp block.
package regfile_pkg;

    localparam int RF_MAX_RD = 4;
    localparam int RF_MAX_W  = 256;

    typedef enum logic [0:0] {
        RF_INIT  = 1'b0,
        RF_READY = 1'b1
    } rf_state_t;

    // Nibble replicated across the widest supported register; callers truncate to DATA_W.
    function automatic logic [RF_MAX_W-1:0] rf_init_pattern(input logic [3:0] idx);
        return {(RF_MAX_W/4){idx}};
    endfunction

endpackage

// File: rtl/regfile_init_seq.sv
// regfile_init_seq: post-reset walk over registers 1..DEPTH-1 emitting the init pattern, then ready.
module regfile_init_seq
    import regfile_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    output logic              init_we,
    output logic [ADDR_W-1:0] init_addr,
    output logic [DATA_W-1:0] init_data,
    output logic              ready
);

    localparam logic [ADDR_W-1:0] LAST = '1;

    rf_state_t         state;
    logic [ADDR_W-1:0] idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RF_INIT;
            idx   <= ADDR_W'(1);
        end else if (state == RF_INIT) begin
            idx   <= idx + ADDR_W'(1);
            state <= (idx == LAST) ? RF_READY : RF_INIT;
        end
    end

    assign init_we   = (state == RF_INIT);
    assign init_addr = idx;
    assign init_data = DATA_W'(rf_init_pattern(4'(idx)));
    assign ready     = (state == RF_READY);

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file, reg 0 hardwired to zero; REGFILE_BYPASS_EN selects write-first reads.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic                     ready
);

    localparam int DEPTH = 2**ADDR_W;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic                     init_we;
    logic [ADDR_W-1:0]        init_addr;
    logic [DATA_W-1:0]        init_data;
    logic                     user_we;
    logic                     we;
    logic [ADDR_W-1:0]        waddr;
    logic [DATA_W-1:0]        wdata;
    logic [DATA_W-1:0]        mem [1:DEPTH-1];
    logic [NUM_RD*DATA_W-1:0] rd_next;

    regfile_init_seq #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_init_seq (
        .clk      (clk),
        .reset    (reset),
        .init_we  (init_we),
        .init_addr(init_addr),
        .init_data(init_data),
        .ready    (ready)
    );

    // The sequencer owns the write port until ready; init_we and ready are mutually exclusive.
    assign user_we = ready && wr_en && (wr_addr != '0);
    assign we      = init_we || user_we;
    assign waddr   = ready ? wr_addr : init_addr;
    assign wdata   = ready ? wr_data : init_data;

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    always_comb begin
        logic [ADDR_W-1:0] ra;
        ra      = '0;
        rd_next = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            ra = rd_addr[p*ADDR_W +: ADDR_W];
            rd_next[p*DATA_W +: DATA_W] = (ra == '0) ? '0 :
                                          (BYPASS && user_we && ra == wr_addr) ? wr_data : mem[ra];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rd_data <= '0;
        else
            rd_data <= ready ? rd_next : '0;
    end

endmodule
